// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared constants for the rf_32 access arbiter.
// Holds the FSM state encoding, OFF/ON levels and the port index names.
package rf_arb_pkg;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;
    localparam logic OFF = 1'b0;
    localparam logic ON  = 1'b1;
    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DBG  = 1'b1;
endpackage

// File: rtl/rf_rr_picker.sv
// rf_rr_picker: 2-way round-robin picker with its priority pointer.
// The pointer names the port that wins a tie; it flips away from each granted port.
module rf_rr_picker
    import rf_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req_i,
    input  logic       take_i,
    output logic       grant_valid_o,
    output logic       grant_idx_o
);
    logic ptr_q;
    assign grant_valid_o = |req_i;
    assign grant_idx_o   = (&req_i) ? ptr_q : (req_i[PORT_DBG] ? PORT_DBG : PORT_CORE);
    always_ff @(posedge clk) begin
        if (!reset_n)
            ptr_q <= PORT_CORE;
        else if (take_i)
            ptr_q <= ~grant_idx_o;
    end
endmodule

// File: rtl/rf_access_arbiter.sv
// rf_access_arbiter: shares one rf_32 between the core (port 0) and debug/loader (port 1).
// Each granted request becomes one setup/start/finish handshake, bounded by a timeout.
module rf_access_arbiter
    import rf_arb_pkg::*;
#(
    parameter int INDEX_SIZE     = 5,
    parameter int REG_SIZE       = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            req,
    input  logic [INDEX_SIZE-1:0] rs0,
    input  logic [INDEX_SIZE-1:0] rt0,
    input  logic [INDEX_SIZE-1:0] wa0,
    input  logic                  we0,
    input  logic [REG_SIZE-1:0]   wd0,
    input  logic [INDEX_SIZE-1:0] rs1,
    input  logic [INDEX_SIZE-1:0] rt1,
    input  logic [INDEX_SIZE-1:0] wa1,
    input  logic                  we1,
    input  logic [REG_SIZE-1:0]   wd1,
    output logic [1:0]            done,
    output logic [1:0]            err,
    output logic [REG_SIZE-1:0]   rdata_a,
    output logic [REG_SIZE-1:0]   rdata_b,
    output logic                  busy,
    output logic                  rf_start,
    output logic [INDEX_SIZE-1:0] rf_read_addr_s,
    output logic [INDEX_SIZE-1:0] rf_read_addr_t,
    output logic [INDEX_SIZE-1:0] rf_write_addr,
    output logic                  rf_write_enabled,
    output logic [REG_SIZE-1:0]   rf_write_data,
    input  logic                  rf_finish,
    input  logic [REG_SIZE-1:0]   rf_outA,
    input  logic [REG_SIZE-1:0]   rf_outB
);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       grant_q, grant_valid, grant_idx, take, timeout, capture;

    assign take    = (state_q == S_IDLE) && grant_valid;
    assign capture = (state_q == S_WAIT) && rf_finish;
    // A finish arriving in the last allowed WAIT cycle still wins over the abort.
    assign timeout = (state_q == S_WAIT) && !rf_finish && (cnt_q == TMO_LAST);

    rf_rr_picker u_picker (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_i         (req),
        .take_i        (take),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
    );

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:   state_d = grant_valid ? S_SETUP : S_IDLE;
            S_SETUP:  state_d = S_STROBE;
            S_STROBE: state_d = S_WAIT;
            S_WAIT:   state_d = rf_finish ? S_RESP : (timeout ? S_IDLE : S_WAIT);
            default:  state_d = S_IDLE;
        endcase
    end

    assign cnt_d = (state_q == S_WAIT) ? cnt_q + 8'd1 : 8'd0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            cnt_q            <= '0;
            grant_q          <= PORT_CORE;
            rf_read_addr_s   <= '0;
            rf_read_addr_t   <= '0;
            rf_write_addr    <= '0;
            rf_write_enabled <= OFF;
            rf_write_data    <= '0;
            rdata_a          <= '0;
            rdata_b          <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (take) begin
                grant_q          <= grant_idx;
                rf_read_addr_s   <= grant_idx ? rs1 : rs0;
                rf_read_addr_t   <= grant_idx ? rt1 : rt0;
                rf_write_addr    <= grant_idx ? wa1 : wa0;
                rf_write_enabled <= grant_idx ? we1 : we0;
                rf_write_data    <= grant_idx ? wd1 : wd0;
            end
            if (timeout)
                rf_write_enabled <= OFF;
            if (capture) begin
                rdata_a <= rf_outA;
                rdata_b <= rf_outB;
            end
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign rf_start = (state_q == S_STROBE || state_q == S_WAIT) ? ON : OFF;
    // Pulses are masked while reset is asserted so an aborted transaction reports nothing.
    assign done     = (reset_n && state_q == S_RESP) ? {grant_q, ~grant_q} : 2'b00;
    assign err      = (reset_n && timeout) ? {grant_q, ~grant_q} : 2'b00;
endmodule

// File: tb/tb_rf_access_arbiter.sv
// tb_rf_access_arbiter: scoreboard bench with an rf_32 stand-in and a transaction-level reference model.
module tb_rf_access_arbiter;
    localparam int TMO   = 15;
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [4:0]  rs0 = '0, rt0 = '0, wa0 = '0, rs1 = '0, rt1 = '0, wa1 = '0;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic [31:0] wd0 = '0, wd1 = '0;
    logic [1:0]  done, err;
    logic [31:0] rdata_a, rdata_b;
    logic        busy, rf_start, rf_write_enabled;
    logic [4:0]  rf_read_addr_s, rf_read_addr_t, rf_write_addr;
    logic [31:0] rf_write_data;
    logic        rf_finish = 1'b0;
    logic [31:0] rf_outA = '0, rf_outB = '0;

    typedef struct { logic [4:0] rs, rt, wa; logic we; logic [31:0] wd; int d; } op_t;
    typedef struct { logic port; logic is_err; op_t op; logic [31:0] a, b; int lat; } exp_t;

    exp_t        exp_q[$];
    int          dly_q[$];
    logic [31:0] ref_mem [32];
    logic [31:0] env_mem [32];
    logic [31:0] last_a = '0, last_b = '0;
    logic        prio = 1'b0;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    rf_access_arbiter #(.INDEX_SIZE(5), .REG_SIZE(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .req(req),
        .rs0(rs0), .rt0(rt0), .wa0(wa0), .we0(we0), .wd0(wd0),
        .rs1(rs1), .rt1(rt1), .wa1(wa1), .we1(we1), .wd1(wd1),
        .done(done), .err(err), .rdata_a(rdata_a), .rdata_b(rdata_b), .busy(busy),
        .rf_start(rf_start), .rf_read_addr_s(rf_read_addr_s), .rf_read_addr_t(rf_read_addr_t),
        .rf_write_addr(rf_write_addr), .rf_write_enabled(rf_write_enabled),
        .rf_write_data(rf_write_data), .rf_finish(rf_finish), .rf_outA(rf_outA), .rf_outB(rf_outB)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, want);
        end
    endtask

    function automatic op_t rnd_op(input int d);
        op_t o;
        o.rs = 5'($urandom); o.rt = 5'($urandom); o.wa = 5'($urandom);
        o.we = 1'($urandom); o.wd = $urandom; o.d = d;
        return o;
    endfunction

    function automatic int pick_d();
        int r;
        r = int'($urandom_range(0, 19));
        return (r == 0) ? NEVER : (r == 1) ? 14 : int'($urandom_range(0, 4));
    endfunction

    // Reference: a transaction reads the old register values, then writes; reg 0 stays zero.
    task automatic predict(input logic p, input op_t o);
        exp_t e;
        e.port = p; e.op = o; e.is_err = (o.d == NEVER);
        if (e.is_err) begin
            e.a = last_a; e.b = last_b; e.lat = TMO + 1;
        end else begin
            e.a = ref_mem[o.rs]; e.b = ref_mem[o.rt]; e.lat = o.d + 3;
            if (o.we && o.wa != 5'd0) ref_mem[o.wa] = o.wd;
            last_a = e.a; last_b = e.b;
        end
        prio = ~p;
        exp_q.push_back(e);
        dly_q.push_back(o.d);
    endtask

    task automatic drive(input logic p, input op_t o);
        if (p) begin rs1 = o.rs; rt1 = o.rt; wa1 = o.wa; we1 = o.we; wd1 = o.wd; end
        else   begin rs0 = o.rs; rt0 = o.rt; wa0 = o.wa; we0 = o.we; wd0 = o.wd; end
    endtask

    task automatic run_round(input logic [1:0] mask, input op_t o0, input op_t o1);
        logic       f;
        logic [1:0] pend;
        bit         began;
        int         n;
        f = (mask == 2'b11) ? prio : mask[1];
        if (mask[f]) predict(f, f ? o1 : o0);
        if (mask[~f]) predict(~f, f ? o0 : o1);
        drive(1'b0, mask[0] ? o0 : rnd_op(0));
        drive(1'b1, mask[1] ? o1 : rnd_op(0));
        req = mask; pend = mask; began = 0; n = 0;
        while (pend != 2'b00 && n < 400) begin
            @(negedge clk);
            n++;
            if (busy) began = 1;
            for (int p = 0; p < 2; p++) begin
                if (pend[p] && (done[p] || err[p])) begin pend[p] = 1'b0; req[p] = 1'b0; end
                if (!pend[p] || (began && p == int'(f))) drive(1'(p), rnd_op(0));
            end
        end
        if (pend != 2'b00) begin
            chk("round_timeout", 64'(pend), 64'd0);
            req = 2'b00; exp_q.delete(); dly_q.delete();
        end
    endtask

    task automatic rst_checks(input string tag);
        chk({tag, "_ctl"}, {done, err, busy, rf_start, rf_write_enabled}, 64'd0);
        chk({tag, "_addr"}, {rf_read_addr_s, rf_read_addr_t, rf_write_addr}, 64'd0);
        chk({tag, "_wd"}, 64'(rf_write_data), 64'd0);
        chk({tag, "_rdata"}, {rdata_a, rdata_b}, 64'd0);
    endtask

    // rf_32 stand-in: finish arrives d cycles after the first WAIT cycle, or never.
    int   left = 0;
    bit   env_pend = 0;
    logic env_prev = 1'b0;
    always @(posedge clk) begin
        rf_finish <= 1'b0;
        if (!reset_n) env_pend = 0;
        else begin
            if (rf_start && !env_prev) begin
                left = (dly_q.size() != 0) ? dly_q.pop_front() : NEVER;
                env_pend = (left != NEVER);
            end
            if (env_pend && rf_start) begin
                if (left == 0) begin
                    rf_finish <= 1'b1;
                    rf_outA <= env_mem[rf_read_addr_s];
                    rf_outB <= env_mem[rf_read_addr_t];
                    if (rf_write_enabled && rf_write_addr != 5'd0) env_mem[rf_write_addr] = rf_write_data;
                    env_pend = 0;
                end else left--;
            end
        end
        env_prev = rf_start;
    end

    bit   tracking = 0, stab_ok = 1, post_err = 0;
    int   lat = 0, edges = 0;
    logic mon_prev = 1'b0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset_n) begin
            tracking = 0; post_err = 0; mon_prev = 1'b0;
        end else begin
            if (post_err) begin chk("busy_after_err", 64'(busy), 64'd0); post_err = 0; end
            if (busy && !tracking) begin tracking = 1; lat = 0; edges = 0; stab_ok = 1; end
            else if (tracking) lat++;
            if (rf_start && !mon_prev) edges++;
            mon_prev = rf_start;
            if (busy && exp_q.size() != 0)
                if ({rf_read_addr_s, rf_read_addr_t, rf_write_addr, rf_write_enabled, rf_write_data} !==
                    {exp_q[0].op.rs, exp_q[0].op.rt, exp_q[0].op.wa, exp_q[0].op.we, exp_q[0].op.wd})
                    stab_ok = 0;
            if ((done | err) != 2'b00) begin
                if (exp_q.size() == 0) chk("unexpected_resp", {done, err}, 64'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("resp_port", 64'(done | err), e.port ? 64'd2 : 64'd1);
                    chk("resp_kind", 64'(err != 2'b00), 64'(e.is_err));
                    chk("latency", 64'(lat), 64'(e.lat));
                    chk("start_edges", 64'(edges), 64'd1);
                    chk("bus_stable", 64'(stab_ok), 64'd1);
                    chk("rdata_a", 64'(rdata_a), 64'(e.a));
                    chk("rdata_b", 64'(rdata_b), 64'(e.b));
                end
                tracking = 0;
                post_err = (err != 2'b00);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t         o, o2;
        logic [31:0] v;
        for (int i = 0; i < 32; i++) begin
            v = (i == 0) ? 32'd0 : $urandom;
            ref_mem[i] = v; env_mem[i] = v;
        end
        ref_mem[3] = 32'hA5A5A5A5; env_mem[3] = 32'hA5A5A5A5;
        ref_mem[4] = 32'h12345678; env_mem[4] = 32'h12345678;
        repeat (3) @(negedge clk);
        rst_checks("reset");
        reset_n = 1'b1;
        @(negedge clk);

        o = rnd_op(0); o.rs = 5'd3; o.rt = 5'd4; o.we = 1'b0;
        run_round(2'b01, o, o);
        chk("single_read_a", 64'(rdata_a), 64'hA5A5A5A5);
        chk("single_read_b", 64'(rdata_b), 64'h12345678);

        o = rnd_op(1); o.wa = 5'd7; o.wd = 32'hDEADBEEF; o.we = 1'b1;
        run_round(2'b10, o, o);
        o = rnd_op(2); o.rs = 5'd7; o.we = 1'b0;
        run_round(2'b10, o, o);
        chk("write_readback", 64'(rdata_a), 64'hDEADBEEF);

        o = rnd_op(0); o.wa = 5'd0; o.we = 1'b1; o.wd = 32'hFFFFFFFF;
        run_round(2'b01, o, o);
        o = rnd_op(0); o.rs = 5'd0; o.rt = 5'd0; o.we = 1'b0;
        run_round(2'b01, o, o);
        chk("reg0_zero", 64'(rdata_a), 64'd0);

        run_round(2'b01, rnd_op(NEVER), rnd_op(0));
        run_round(2'b01, rnd_op(1), rnd_op(0));
        run_round(2'b10, rnd_op(0), rnd_op(14));

        @(negedge clk);
        drive(1'b0, rnd_op(NEVER));
        req = 2'b01;
        repeat (6) @(negedge clk);
        chk("mid_wait_start", 64'(rf_start), 64'd1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1; req = 2'b00;
        rst_checks("midrst");
        prio = 1'b0; last_a = '0; last_b = '0;

        for (int k = 0; k < 2; k++) begin
            o = rnd_op(int'($urandom_range(0, 3)));
            o2 = rnd_op(int'($urandom_range(0, 3)));
            run_round(2'b11, o, o2);
        end

        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_round(2'($urandom_range(1, 3)), rnd_op(pick_d()), rnd_op(pick_d()));
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rf_access_arbiter.md
Name: rf_access_arbiter

Overview:
- Shares one rf_32 register file between two requesters: port 0 is the core datapath, port 1 is the debug/loader.
- Converts each requester's level-held request into a single clean rf_32 transaction: address/data setup, `start` rising edge, wait for `finish`.
- Captures outA/outB and returns them with a one-cycle done pulse.
- Bounds every transaction with a timeout so a hung register file cannot stall the core forever.

Parameters:
- INDEX_SIZE, 5, register index width.
- REG_SIZE, 32, register data width.
- TIMEOUT_CYCLES, 15, max cycles in WAIT before abort; legal range 1..255.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- req  in  2  per-port request; level, held high until that port's done or err.
- rs0, rt0, wa0  in  INDEX_SIZE each  port 0 read-s, read-t and write addresses.
- we0  in  1  port 0 write enable.
- wd0  in  REG_SIZE  port 0 write data.
- rs1, rt1, wa1, we1, wd1  in  as port 0  port 1 equivalents.
- done  out  2  per-port one-cycle completion pulse.
- err  out  2  per-port one-cycle timeout pulse.
- rdata_a  out  REG_SIZE  captured outA; valid from done and held until the next capture.
- rdata_b  out  REG_SIZE  captured outB; same timing as rdata_a.
- busy  out  1  high whenever state is not IDLE.
- rf_start  out  1  to rf_32 start.
- rf_read_addr_s, rf_read_addr_t, rf_write_addr  out  INDEX_SIZE  to rf_32.
- rf_write_enabled  out  1  to rf_32.
- rf_write_data  out  REG_SIZE  to rf_32.
- rf_finish  in  1  from rf_32 finish.
- rf_outA, rf_outB  in  REG_SIZE  from rf_32.

Behaviour:
- Reset (reset_n low at a clk edge):
  - State goes to IDLE; priority pointer goes to port 0.
  - All outputs are 0, including rf_* buses; rf_write_enabled is 0.
  - Reset mid-transaction aborts it silently: no done, no err.
- FSM states: IDLE, SETUP, STROBE, WAIT, RESP.
- IDLE:
  - If any req bit is high, grant one port and move to SETUP.
  - Tie-break is round-robin: the port not granted most recently wins. The pointer updates on grant.
- Grant latch: the granted port's rs/rt/wa/we/wd are registered onto the rf_* outputs at grant. They stay stable through RESP; later requester changes are ignored.
- SETUP: rf_start = 0 for exactly one cycle, so the address is stable before the start edge.
- STROBE: rf_start = 1 for one cycle, then move to WAIT.
- WAIT:
  - rf_start stays 1 and the timeout counter increments.
  - rf_finish = 1: capture rf_outA/rf_outB into rdata_a/rdata_b and move to RESP.
  - Counter reaches TIMEOUT_CYCLES without finish: pulse err[grant], drop rf_write_enabled to 0, return to IDLE. rdata is not updated.
  - rf_finish already high on WAIT's first cycle is legal; the transaction completes after 1 WAIT cycle.
- RESP:
  - rf_start = 0 and done[grant] = 1 for one cycle, then IDLE.
  - Minimum transaction latency: grant to done = 4 cycles.
- A requester must drop req in the cycle after done/err. If req is still high in IDLE, it is treated as a new transaction.
- Simultaneous events:
  - Both req high in IDLE: round-robin decides.
  - Losing port waits and is served next; max wait is one transaction.
- rf_start stays low in IDLE, so rf_32 sees exactly one rising edge per transaction.
- Writes to register 0 pass through unchanged; rf_32 zeroes register 0 itself.

Decomposition:
- Package rf_arb_pkg holds:
  - FSM state encoding (3-bit localparams);
  - OFF/ON constants;
  - port index constants PORT_CORE = 0 and PORT_DBG = 1.
- One sub-module, rf_rr_picker: combinational 2-way round-robin picker plus a pointer register. Inputs are req and pointer; outputs are grant_valid and grant_idx.

Test Plan:
- Single read: port 0 requests rs0=3, rt0=4, we0=0; model reg3=0xA5A5A5A5, reg4=0x12345678, finish 1 cycle after start → done[0] 4 cycles after grant, rdata_a=0xA5A5A5A5, rdata_b=0x12345678, exactly one start rising edge.
- Write then read: port 1 writes wa1=7, wd1=0xDEADBEEF, then reads rs1=7 → second rdata_a=0xDEADBEEF; write to wa=0 followed by rs=0 → rdata_a=0.
- Contention: req=2'b11 held continuously for 4 transactions → grant order 0,1,0,1; done never asserted on both bits in the same cycle.
- Timeout: model never asserts finish, TIMEOUT_CYCLES=15 → err[0] pulses exactly 15 WAIT cycles after entry; rdata unchanged; busy=0 the next cycle; next request is served normally.
- Reset mid-WAIT: reset_n low for 1 cycle during WAIT → all outputs 0, no done/err, state IDLE; pointer back to port 0, so simultaneous req grants port 0.
- Address stability: randomise requester inputs every cycle during a transaction → rf_* buses equal the grant-cycle values from SETUP through RESP.
